irq_ctrl: RTL and testbench

Interrupt controller that drives the fetch stage's `interrupt` input. It collects rising-edge requests from peripherals (GPU/SPI/UART/controller inputs), masks and prioritises them, and issues a single-cycle `interrupt` pulse only when the pipeline can accept it. It then holds off further interrupts until the handler returns through `rti` or `rsi`, plus a fixed recovery window matching fetch's post-interrupt NOP/redirect window.

---
 rtl/irq_ctrl.sv | 130 +++++++++++++
 tb/tb_irq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes peripheral request edges, masks and prioritizes them,
// and issues a single-cycle interrupt pulse to fetch, then holds off until return plus recovery.
module irq_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int IDW     = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               stall_mem,
    input  logic               flush,
    input  logic               halt,
    input  logic               rti,
    input  logic               rsi,
    output logic               interrupt,
    output logic               in_service,
    output logic [IDW-1:0]     int_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] irq_en
);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        SERVICE,
        RECOVER
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [IDW-1:0]     int_id_q, int_id_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] irq_en_q, irq_en_d;
    logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clear_mask;
    logic [IDW-1:0]     winner;
    logic               has_eligible;

    // Two-flop synchronizer followed by a delay flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= irq_src;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edges        = s2_q & ~s3_q;
    assign eligible     = pending_q & irq_en_q;
    assign has_eligible = |eligible;

    // Fixed priority: the lowest eligible index wins, so scan from the top down.
    always_comb begin
        winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = IDW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        int_id_d   = int_id_q;
        clear_mask = '0;
        case (state_q)
            IDLE: begin
                if (has_eligible && !(stall_mem || flush || halt)) begin
                    state_d    = FIRE;
                    int_id_d   = winner;
                    clear_mask = NUM_SRC'(1) << winner;
                end
            end
            FIRE: begin
                state_d = SERVICE;
            end
            SERVICE: begin
                if (rti || rsi) begin
                    state_d = RECOVER;
                    cnt_d   = 2'd3;
                end
            end
            RECOVER: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A new edge landing on the clearing edge re-arms the source.
    assign pending_d = (pending_q & ~clear_mask) | edges;
    assign irq_en_d  = en_we ? en_wdata : irq_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            int_id_q  <= '0;
            pending_q <= '0;
            irq_en_q  <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_id_q  <= int_id_d;
            pending_q <= pending_d;
            irq_en_q  <= irq_en_d;
        end
    end

    assign interrupt  = (state_q == FIRE);
    assign in_service = (state_q == FIRE) || (state_q == SERVICE);
    assign int_id     = int_id_q;
    assign pending    = pending_q;
    assign irq_en     = irq_en_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a cycle-count based reference model.
module tb_irq_ctrl;

    localparam int NS  = 4;
    localparam int IDW = 2;

    logic           clk;
    logic           rst;
    logic [NS-1:0]  irqSrc;
    logic           enWe;
    logic [NS-1:0]  enWdata;
    logic           stallMem;
    logic           flushIn;
    logic           haltIn;
    logic           rtiIn;
    logic           rsiIn;
    logic           interrupt;
    logic           inService;
    logic [IDW-1:0] intId;
    logic [NS-1:0]  pending;
    logic [NS-1:0]  irqEn;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(.NUM_SRC(NS), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irqSrc),
        .en_we      (enWe),
        .en_wdata   (enWdata),
        .stall_mem  (stallMem),
        .flush      (flushIn),
        .halt       (haltIn),
        .rti        (rtiIn),
        .rsi        (rsiIn),
        .interrupt  (interrupt),
        .in_service (inService),
        .int_id     (intId),
        .pending    (pending),
        .irq_en     (irqEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: handler activity plus the cycle at which firing becomes legal again.
    logic [NS-1:0]  mPend;
    logic [NS-1:0]  mEn;
    logic [IDW-1:0] mId;
    logic           mPulse;
    logic           mBusy;
    int             mReady;
    int             cyc;
    logic [NS-1:0]  hist[$];

    task automatic modelReset();
        mPend  = '0;
        mEn    = '1;
        mId    = '0;
        mPulse = 1'b0;
        mBusy  = 1'b0;
        mReady = 0;
        hist.delete();
        repeat (3) hist.push_back('0);
    endtask

    task automatic modelEdge();
        logic [NS-1:0] newEdges;
        logic [NS-1:0] elig;
        logic          canFire;
        logic          retNow;
        logic          found;
        int            win;
        if (rst) begin
            modelReset();
        end else begin
            newEdges = hist[hist.size()-2] & ~hist[hist.size()-3];
            elig     = mPend & mEn;
            canFire  = !mBusy && (cyc >= mReady) && (elig != '0) && !(stallMem || flushIn || haltIn);
            retNow   = mBusy && !mPulse && (rtiIn || rsiIn);
            win      = 0;
            found    = 1'b0;
            for (int i = 0; i < NS; i++) begin
                if (elig[i] && !found) begin
                    win   = i;
                    found = 1'b1;
                end
            end
            if (canFire) begin
                mPend[win] = 1'b0;
                mId        = IDW'(win);
            end
            mPend = mPend | newEdges;
            if (enWe) mEn = enWdata;
            if (retNow) begin
                mBusy  = 1'b0;
                mReady = cyc + 4;
            end
            if (canFire) mBusy = 1'b1;
            mPulse = canFire;
            hist.push_back(irqSrc);
            if (hist.size() > 6) void'(hist.pop_front());
        end
        cyc++;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkOutput();
        checkVal("model_interrupt", 32'(interrupt), 32'(mPulse));
        checkVal("model_in_service", 32'(inService), 32'(mBusy));
        checkVal("model_int_id", 32'(intId), 32'(mId));
        checkVal("model_pending", 32'(pending), 32'(mPend));
        checkVal("model_irq_en", 32'(irqEn), 32'(mEn));
    endtask

    task automatic applyStimulus(input logic [NS-1:0] src, input logic we, input logic [NS-1:0] wdata,
                                 input logic stl, input logic fl, input logic hl,
                                 input logic rt, input logic rs);
        irqSrc   = src;
        enWe     = we;
        enWdata  = wdata;
        stallMem = stl;
        flushIn  = fl;
        haltIn   = hl;
        rtiIn    = rt;
        rsiIn    = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic quiesce();
        applyStimulus('0, 0, '0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        applyStimulus('0, 0, '0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus('0, 0, '0, 0, 0, 0, 0, 0);
        repeat (6) tick();
    endtask

    task automatic doAsyncReset();
        #2 rst = 1'b1;
        #1 modelReset();
        checkOutput();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NS-1:0]  src;
        logic           rt;
        logic           rs;
        logic           expInt;
        logic           expSvc;
        logic [IDW-1:0] expId;
        logic [NS-1:0]  expPend;
    } vec_t;

    vec_t vecs[13];

    int firstPulse;
    int secondPulse;
    int firstId;
    int secondId;
    int sawPulse;
    logic [NS-1:0] rSrc;

    initial begin
        vecs[0]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[1]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[2]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100};
        vecs[3]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000};
        vecs[4]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000};
        vecs[5]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000};
        vecs[6]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000};
        vecs[7]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100};
        vecs[8]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100};
        vecs[9]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000};
        vecs[10] = '{4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000};
        vecs[11] = '{4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000};
        vecs[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000};

        cyc = 0;
        rst = 1'b1;
        applyStimulus('0, 0, '0, 0, 0, 0, 0, 0);
        modelReset();
        repeat (2) tick();
        checkVal("reset_irq_en", 32'(irqEn), 32'hF);
        checkVal("reset_in_service", 32'(inService), 32'h0);
        rst = 1'b0;

        for (int j = 0; j < 13; j++) begin
            applyStimulus(vecs[j].src, 0, '0, 0, 0, 0, vecs[j].rt, vecs[j].rs);
            tick();
            checkVal($sformatf("vec%0d_interrupt", j), 32'(interrupt), 32'(vecs[j].expInt));
            checkVal($sformatf("vec%0d_in_service", j), 32'(inService), 32'(vecs[j].expSvc));
            checkVal($sformatf("vec%0d_int_id", j), 32'(intId), 32'(vecs[j].expId));
            checkVal($sformatf("vec%0d_pending", j), 32'(pending), 32'(vecs[j].expPend));
        end

        // Reset in the middle of a handler with two sources still pending.
        quiesce();
        for (int t = 0; t < 5; t++) begin
            applyStimulus(4'b0111, 0, '0, 0, 0, 0, 0, 0);
            tick();
        end
        checkVal("rstseq_pending_before", 32'(pending), 32'h6);
        checkVal("rstseq_in_service_before", 32'(inService), 32'h1);
        applyStimulus('0, 0, '0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 modelReset();
        checkVal("rstseq_async_in_service", 32'(inService), 32'h0);
        checkVal("rstseq_async_pending", 32'(pending), 32'h0);
        checkVal("rstseq_async_int_id", 32'(intId), 32'h0);
        checkVal("rstseq_async_irq_en", 32'(irqEn), 32'hF);
        repeat (2) tick();
        rst = 1'b0;
        sawPulse = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (interrupt) sawPulse = 1;
        end
        checkVal("rstseq_no_pulse", 32'(sawPulse), 32'h0);

        // Priority between two simultaneous requests.
        quiesce();
        firstPulse = -1; secondPulse = -1; firstId = -1; secondId = -1;
        for (int t = 0; t < 14; t++) begin
            applyStimulus(4'b1010, 0, '0, 0, 0, 0, (t == 5), 0);
            tick();
            if (interrupt) begin
                if (firstPulse < 0) begin
                    firstPulse = t; firstId = int'(intId);
                end else begin
                    secondPulse = t; secondId = int'(intId);
                end
            end
        end
        checkVal("prio_first_time", 32'(firstPulse), 32'd3);
        checkVal("prio_first_id", 32'(firstId), 32'd1);
        checkVal("prio_second_time", 32'(secondPulse), 32'd9);
        checkVal("prio_second_id", 32'(secondId), 32'd3);

        // Deferral by stall_mem, flush, then halt.
        for (int which = 0; which < 3; which++) begin
            quiesce();
            firstPulse = -1;
            for (int t = 0; t < 12; t++) begin
                applyStimulus(4'b0001, 0, '0,
                              (which == 0) && (t >= 2) && (t <= 6),
                              (which == 1) && (t >= 2) && (t <= 6),
                              (which == 2) && (t >= 2) && (t <= 6), 0, 0);
                tick();
                if (interrupt && firstPulse < 0) firstPulse = t;
            end
            checkVal($sformatf("defer%0d_pulse_time", which), 32'(firstPulse), 32'd7);
        end

        // Masked source stays pending without firing until re-enabled.
        quiesce();
        applyStimulus('0, 1, 4'b1011, 0, 0, 0, 0, 0);
        tick();
        sawPulse = 0;
        for (int t = 0; t < 20; t++) begin
            applyStimulus(4'b0100, 0, '0, 0, 0, 0, 0, 0);
            tick();
            if (interrupt) sawPulse = 1;
        end
        checkVal("mask_no_pulse", 32'(sawPulse), 32'h0);
        checkVal("mask_pending2", 32'(pending[2]), 32'h1);
        checkVal("mask_irq_en", 32'(irqEn), 32'hB);
        applyStimulus(4'b0100, 1, 4'b1111, 0, 0, 0, 0, 0);
        tick();
        checkVal("mask_irq_en_restored", 32'(irqEn), 32'hF);
        applyStimulus(4'b0100, 0, '0, 0, 0, 0, 0, 0);
        tick();
        checkVal("mask_pulse", 32'(interrupt), 32'h1);
        checkVal("mask_pulse_id", 32'(intId), 32'h2);

        // Re-arm: a second edge lands on the same edge that clears the pending bit.
        quiesce();
        firstPulse = -1; secondPulse = -1; secondId = -1;
        for (int t = 0; t < 14; t++) begin
            applyStimulus((t == 1) ? 4'b0000 : 4'b0001, 0, '0, (t == 3), 0, 0, 0, (t == 6));
            tick();
            if (t == 4) checkVal("rearm_pending0", 32'(pending[0]), 32'h1);
            if (interrupt) begin
                if (firstPulse < 0) firstPulse = t;
                else begin
                    secondPulse = t; secondId = int'(intId);
                end
            end
        end
        checkVal("rearm_first_time", 32'(firstPulse), 32'd4);
        checkVal("rearm_second_time", 32'(secondPulse), 32'd10);
        checkVal("rearm_second_id", 32'(secondId), 32'd0);

        // Randomized traffic against the reference model.
        quiesce();
        rSrc = '0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                doAsyncReset();
            end else begin
                for (int b = 0; b < NS; b++) begin
                    if ($urandom_range(0, 5) == 0) rSrc[b] = ~rSrc[b];
                end
                applyStimulus(rSrc,
                              ($urandom_range(0, 19) == 0),
                              NS'($urandom),
                              ($urandom_range(0, 5) == 0),
                              ($urandom_range(0, 7) == 0),
                              ($urandom_range(0, 7) == 0),
                              ($urandom_range(0, 7) == 0),
                              ($urandom_range(0, 7) == 0));
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
